// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
package arm_mem_pkg;

  // Access sequencer states: idle, low half-word, high half-word, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned ADDR_BASE = 1024;
  localparam int unsigned SRAM_DW   = 16;
  localparam int unsigned SRAM_AW   = 18;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one SRAM half-word phase.
module sram_phase_counter #(
  parameter int unsigned WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  logic [3:0] cnt;

  // Count cycles within a phase; cleared on reset and on every phase entry.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + 4'd1;
  end

  assign tc = (cnt == 4'(WAIT - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: 32-bit loads/stores over a 16-bit SRAM in two
// half-word phases, stalling the upstream pipeline while an access runs.
module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_BASE = arm_mem_pkg::ADDR_BASE,
  parameter int unsigned SRAM_WAIT = 2,
  parameter int unsigned SRAM_AW   = arm_mem_pkg::SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [3:0]         dest_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_rm_in,
  output logic               freeze,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        alu_res_out,
  output logic [31:0]        mem_data_out,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  import arm_mem_pkg::*;

  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  state_t               state, state_nx;
  logic                 req;
  logic                 in_phase;
  logic                 is_wr;
  logic                 tc;
  logic                 cnt_clr;
  logic [SRAM_AW-2:0]   word;
  logic [SRAM_DW-1:0]   lo_q;

  assign req      = mem_r_en_in | mem_w_en_in;
  assign in_phase = (state == LO) || (state == HI);
  // Half-word pair index; low offset bits and out-of-range bits drop silently.
  assign word     = (SRAM_AW-1)'((alu_res_in - BASE) >> 2);

  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign dest_out     = dest_in;
  assign alu_res_out  = alu_res_in;

  // Clearing on terminal count restarts the count for the phase being entered.
  assign cnt_clr = ~in_phase | tc;

  sram_phase_counter #(
    .WAIT (SRAM_WAIT)
  ) u_phase_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .tc  (tc)
  );

  // Next-state sequencing of the two half-word phases.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LO;
      LO:      if (tc)  state_nx = HI;
      HI:      if (tc)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched op type and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      is_wr        <= 1'b0;
      lo_q         <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) is_wr <= mem_w_en_in;
      if (state == LO && tc && !is_wr) lo_q <= sram_dq_in;
      // High half lands directly in the output register so a later read's
      // low phase cannot disturb the value still being presented.
      if (state == HI && tc && !is_wr) mem_data_out <= {sram_dq_in, lo_q};
    end
  end

  // Stall and SRAM pin drive; everything is forced idle while rst is high.
  always_comb begin
    freeze      = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (!rst) begin
      freeze = ((state == IDLE) && req) || in_phase;
      if (state == LO) sram_addr = {word, 1'b0};
      else if (state == HI) sram_addr = {word, 1'b1};
      if (in_phase && is_wr) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state == LO) ? val_rm_in[15:0] : val_rm_in[31:16];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl with an SRAM model and a
// transaction-level reference of the expected pin and data behaviour.
module tb_mem_stage_sram_ctrl;

  localparam int          W    = 2;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        freeze, wb_en_out, mem_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .ADDR_BASE (1024),
    .SRAM_WAIT (W),
    .SRAM_AW   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .dest_in      (dest_in),
    .alu_res_in   (alu_res_in),
    .val_rm_in    (val_rm_in),
    .freeze       (freeze),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .dest_out     (dest_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_dq_in   (sram_dq_in),
    .sram_we_n    (sram_we_n)
  );

  // External SRAM model: asynchronous read, write on rising edge when strobed.
  logic [15:0] sram [0:(1<<AW)-1];
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

  function automatic logic [15:0] init_hw(int unsigned a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  // ---------------- reference model ----------------
  int total = 0;
  int bad   = 0;
  logic        chk_en = 1'b0;
  logic        in_rst;
  int          k = -1;          // cycle index within the current access, -1 = none
  logic        m_rd, m_wr, m_wb;
  logic [3:0]  m_dest;
  logic [31:0] m_alu, m_rm;
  logic [31:0] held = '0;       // value mem_data_out must present
  logic [31:0] ref_mem [int];   // 32-bit words written by stores

  logic        obs_fr  [0:31];
  logic        obs_we  [0:31];
  logic [31:0] obs_addr[0:31];
  logic [15:0] obs_dq  [0:31];
  logic [31:0] obs_mdo [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] expected_read(logic [31:0] a);
    int w = word_of(a);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_hw(2*w + 1), init_hw(2*w)};
  endfunction

  // Per-cycle comparison of every output against the access timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        lo, hi, wact, e_fr;
      logic [31:0] e_addr;
      logic [15:0] e_dq;
      lo = 0; hi = 0; e_fr = 0; e_addr = '0;
      if (!in_rst && k >= 0) begin
        lo   = (k >= 1) && (k <= W);
        hi   = (k > W) && (k <= 2*W);
        e_fr = (k <= 2*W);
        if (lo) e_addr = 32'(word_of(m_alu) * 2);
        if (hi) e_addr = 32'(word_of(m_alu) * 2 + 1);
      end
      wact = m_wr && (lo || hi) && !in_rst;
      e_dq = !wact ? 16'h0 : (lo ? m_rm[15:0] : m_rm[31:16]);
      check("wb_pass",   wb_en_out,    m_wb);
      check("rd_pass",   mem_r_en_out, m_rd);
      check("dest_pass", dest_out,     m_dest);
      check("alu_pass",  alu_res_out,  m_alu);
      check("freeze",    freeze,       e_fr);
      check("addr",      sram_addr,    e_addr);
      check("we_n",      sram_we_n,    !wact);
      check("oe",        sram_dq_oe,   wact);
      check("dq_out",    sram_dq_out,  e_dq);
      check("mem_data",  mem_data_out, held);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] rm);
    m_rd = rd; m_wr = wr; m_alu = alu; m_rm = rm;
    m_wb = 1'($urandom); m_dest = 4'($urandom);
    mem_r_en_in = rd; mem_w_en_in = wr; alu_res_in = alu; val_rm_in = rm;
    wb_en_in = m_wb; dest_in = m_dest;
  endtask

  task automatic sample(input int i);
    @(negedge clk);
    obs_fr[i] = freeze; obs_we[i] = sram_we_n; obs_addr[i] = 32'(sram_addr);
    obs_dq[i] = sram_dq_out; obs_mdo[i] = mem_data_out;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] rm);
    drive(rd, wr, alu, rm);
    for (int i = 0; i <= 2*W + 1; i++) begin
      k = i;
      if (rd && !wr && i == 2*W + 1) held = expected_read(alu);
      sample(i);
      step();
    end
    if (wr) ref_mem[word_of(alu)] = rm;
    k = -1;
  endtask

  task automatic idle_cycle(input logic [31:0] alu);
    drive(1'b0, 1'b0, alu, $urandom);
    k = -1;
    sample(0);
    step();
  endtask

  initial begin
    int nfr;
    logic first_done_fr;
    logic [31:0] rv;

    for (int i = 0; i < (1 << AW); i++) sram[i] = init_hw(i);
    rst = 1'b1; in_rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_mdo",    mem_data_out, 32'h0);
    check("rst_freeze", freeze,       1'b0);
    check("rst_we_n",   sram_we_n,    1'b1);
    check("rst_addr",   32'(sram_addr), 32'h0);
    step();
    rst = 1'b0; in_rst = 1'b0;

    // Directed store: 1032 -> half-words 4/5.
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    nfr = 0;
    for (int i = 0; i <= 2*W + 1; i++) nfr += int'(obs_fr[i]);
    check("st_freeze_cycles", nfr, 5);
    check("st_addr_lo",  obs_addr[1], 32'd4);
    check("st_addr_lo2", obs_addr[2], 32'd4);
    check("st_dq_lo",    obs_dq[1],   16'hBEEF);
    check("st_we_lo",    obs_we[1],   1'b0);
    check("st_addr_hi",  obs_addr[3], 32'd5);
    check("st_dq_hi",    obs_dq[4],   16'hDEAD);
    check("st_done_we",  obs_we[5],   1'b1);
    check("st_done_fr",  obs_fr[5],   1'b0);

    // Directed load from the same address.
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    check("ld_done_mdo", obs_mdo[5], 32'hDEADBEEF);
    check("ld_done_fr",  obs_fr[5],  1'b0);
    idle_cycle(32'h0);
    check("ld_hold_mdo", obs_mdo[0], 32'hDEADBEEF);

    // Non-memory instruction passes straight through.
    idle_cycle(32'h55);
    check("nm_alu",    obs_addr[0] == 32'h0 ? alu_res_out : 32'hFFFF_FFFF, 32'h55);
    check("nm_freeze", obs_fr[0], 1'b0);
    check("nm_we_n",   obs_we[0], 1'b1);

    // Both enables: behaves as a store to half-words 0/1.
    access(1'b1, 1'b1, 32'd1024, 32'h12345678);
    check("both_addr_lo", obs_addr[1], 32'd0);
    check("both_addr_hi", obs_addr[3], 32'd1);
    check("both_we",      obs_we[2],   1'b0);
    check("both_mdo",     obs_mdo[5],  32'hDEADBEEF);

    // Back-to-back load then store with a new address.
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("b2b_ld_mdo", obs_mdo[5], 32'h12345678);
    first_done_fr = obs_fr[5];
    access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
    check("b2b_gap_fr",   first_done_fr, 1'b0);
    check("b2b_start_fr", obs_fr[0],     1'b1);
    check("b2b_addr",     obs_addr[1],   32'd8);

    // Address below the base wraps silently.
    access(1'b0, 1'b1, 32'h10, 32'hA5A55A5A);
    check("wrap_addr", obs_addr[1], 32'h3FE08);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check("wrap_mdo", obs_mdo[5], 32'hA5A55A5A);

    // Reset during the second HI cycle of a store to 1048.
    drive(1'b0, 1'b1, 32'd1048, 32'h0BADC0DE);
    for (int i = 0; i <= W + 1; i++) begin
      k = i;
      sample(i);
      step();
    end
    // Both halves were strobed before reset took over the strobe.
    ref_mem[word_of(32'd1048)] = 32'h0BADC0DE;
    rst = 1'b1; in_rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    k = -1;
    sample(0);
    check("rst_hi_we_n",   obs_we[0], 1'b1);
    check("rst_hi_freeze", obs_fr[0], 1'b0);
    step();
    rst = 1'b0; in_rst = 1'b0; held = '0;
    sample(0);
    check("rst_hi_mdo",  obs_mdo[0], 32'h0);
    check("rst_hi_idle", obs_fr[0],  1'b0);
    step();
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    check("post_rst_ld", obs_mdo[5], 32'hDEADBEEF);

    // Randomised mix of loads, stores, combined enables and idle cycles.
    for (int n = 0; n < 80; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rv = $urandom;
      else rv = BASE + $urandom_range(0, 255);
      case (op)
        0: idle_cycle(rv);
        1: access(1'b1, 1'b0, rv, $urandom);
        2: access(1'b0, 1'b1, rv, $urandom);
        default: access(1'b1, 1'b1, rv, $urandom);
      endcase
      if ($urandom_range(0, 1) == 1) idle_cycle($urandom);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
